// File: rtl/lc3_arb_pkg.sv
// Shared arbitration constants and elaboration helpers for LC-3 arbitrated muxes.
// No logic; constants and a constant function only.
// No handshake; not applicable.
package lc3_arb_pkg;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Rotating-priority request search: first set req starting at ptr (or 0 in fixed mode).
// Purely combinational, zero latency.
// No handshake; the caller qualifies the result.
module arb_picker
    import lc3_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2,
    parameter int MODE = ARB_MODE_FIXED
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] idx
);

    always_comb begin
        int start;
        int c;
        logic [SELW-1:0] ci;
        any   = 1'b0;
        idx   = '0;
        start = 0;
        c     = 0;
        ci    = '0;
        // An out-of-range pointer falls back to channel 0 so no index >= NCH is ever formed.
        if (MODE == ARB_MODE_RR && int'(ptr) < NCH) start = int'(ptr);
        for (int k = 0; k < NCH; k++) begin
            c = start + k;
            if (c >= NCH) c = c - NCH;
            ci = SELW'(c);
            if (!any && req[ci]) begin
                any = 1'b1;
                idx = ci;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux (fixed priority or round-robin) into a single registered output slot.
// Latency: one cycle from acceptance to out_valid; one transfer per cycle while out_ready=1.
// Backpressure: out_valid & !out_ready stalls the slot, drops all in_ready, and freezes rr_ptr.
module arb_mux
    import lc3_arb_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int SELW     = 2,
    parameter int DATASIZE = 16,
    parameter int MODE     = ARB_MODE_FIXED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*DATASIZE-1:0] in_data,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    output logic [DATASIZE-1:0]     out_data,
    output logic [SELW-1:0]         out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (SELW != clog2(NCH) || NCH < 2 || NCH > 16) begin : g_bad_nch
        $error("arb_mux: SELW must equal clog2(NCH) with NCH in 2..16");
    end
    if (MODE != ARB_MODE_FIXED && MODE != ARB_MODE_RR) begin : g_bad_mode
        $error("arb_mux: MODE must be 0 or 1");
    end

    logic                load;
    logic                any;
    logic                take;
    logic [SELW-1:0]     winner;
    logic [SELW-1:0]     rr_ptr;
    logic [DATASIZE-1:0] win_data;

    arb_picker #(
        .NCH  (NCH),
        .SELW (SELW),
        .MODE (MODE)
    ) u_picker (
        .req (in_valid),
        .ptr (rr_ptr),
        .any (any),
        .idx (winner)
    );

    assign load = !out_valid || out_ready;
    assign take = load && any;

    always_comb begin
        in_ready = '0;
        win_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = take && !rst && (winner == SELW'(i));
            if (winner == SELW'(i)) win_data = in_data[i*DATASIZE +: DATASIZE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= winner;
            // Explicit wrap so non-power-of-two NCH never points past the last channel.
            if (MODE == ARB_MODE_RR)
                rr_ptr <= (winner == SELW'(NCH - 1)) ? '0 : winner + SELW'(1);
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Randomized bench: fixed-priority NCH=4, round-robin NCH=4 and round-robin NCH=3 muxes
// checked against a per-instance transaction-level reference model.
module tb_arb_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] dat [3][4];
    logic [3:0]  iv   [3];
    logic        ordy [3];

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [15:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;
    logic        ov0, ov1, ov2;

    logic [3:0]  ir_a [3];
    logic [15:0] od_a [3];
    logic [1:0]  os_a [3];
    logic        ov_a [3];

    assign ir_a[0] = ir0;
    assign ir_a[1] = ir1;
    assign ir_a[2] = {1'b0, ir2};
    assign od_a[0] = od0;
    assign od_a[1] = od1;
    assign od_a[2] = od2;
    assign os_a[0] = os0;
    assign os_a[1] = os1;
    assign os_a[2] = os2;
    assign ov_a[0] = ov0;
    assign ov_a[1] = ov1;
    assign ov_a[2] = ov2;

    arb_mux #(.NCH(4), .SELW(2), .DATASIZE(16), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .in_data({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
        .in_valid(iv[0]), .in_ready(ir0),
        .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(ordy[0])
    );

    arb_mux #(.NCH(4), .SELW(2), .DATASIZE(16), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .in_data({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
        .in_valid(iv[1]), .in_ready(ir1),
        .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(ordy[1])
    );

    arb_mux #(.NCH(3), .SELW(2), .DATASIZE(16), .MODE(1)) dut_rr3 (
        .clk(clk), .rst(rst),
        .in_data({dat[2][2], dat[2][1], dat[2][0]}),
        .in_valid(iv[2][2:0]), .in_ready(ir2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(ordy[2])
    );

    int checks = 0;
    int errors = 0;

    int nch  [3] = '{4, 4, 3};
    int mode [3] = '{0, 1, 1};

    // Reference model: one output slot and a "next to serve" pointer per instance.
    bit          m_v [3];
    logic [15:0] m_d [3];
    int          m_s [3];
    int          m_p [3];
    logic [3:0]  exp_ir [3];
    bit          n_v [3];
    logic [15:0] n_d [3];
    int          n_s [3];
    int          n_p [3];
    bit          rnd_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int n, input int p);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_p[k] = 0;
        end
    endtask

    // Called mid-cycle: compare DUT with model, then work out the model's state after the edge.
    task automatic check_and_predict();
        for (int k = 0; k < 3; k++) begin
            bit ld;
            int w;
            ld = !m_v[k] || ordy[k];
            w  = pick(iv[k], nch[k], mode[k] == 1 ? m_p[k] : 0);
            exp_ir[k] = (!rst && ld && w >= 0) ? (4'd1 << w) : 4'd0;
            chk($sformatf("d%0d_in_ready", k), 32'(ir_a[k]), 32'(exp_ir[k]));
            chk($sformatf("d%0d_out_valid", k), 32'(ov_a[k]), 32'(m_v[k]));
            chk($sformatf("d%0d_out_data", k), 32'(od_a[k]), 32'(m_d[k]));
            chk($sformatf("d%0d_out_sel", k), 32'(os_a[k]), 32'(m_s[k]));
            n_v[k] = m_v[k]; n_d[k] = m_d[k]; n_s[k] = m_s[k]; n_p[k] = m_p[k];
            if (rst) begin
                n_v[k] = 1'b0; n_d[k] = '0; n_s[k] = 0; n_p[k] = 0;
            end else if (ld && w >= 0) begin
                n_v[k] = 1'b1; n_d[k] = dat[k][w]; n_s[k] = w;
                if (mode[k] == 1) n_p[k] = (w + 1) % nch[k];
            end else if (ld) begin
                n_v[k] = 1'b0;
            end
        end
    endtask

    task automatic new_stimulus();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nch[k]; i++) begin
                if (!iv[k][i] || exp_ir[k][i]) begin
                    if (rnd_en) begin
                        iv[k][i]  = ($urandom_range(0, 99) < 60);
                        dat[k][i] = 16'($urandom);
                    end else begin
                        iv[k][i]  = 1'b1;
                        dat[k][i] = 16'hA000 + 16'(i);
                    end
                end
            end
            ordy[k] = rnd_en ? ($urandom_range(0, 99) < 70) : 1'b1;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_and_predict();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_v[k] = n_v[k]; m_d[k] = n_d[k]; m_s[k] = n_s[k]; m_p[k] = n_p[k];
        end
        new_stimulus();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; ordy[k] = 1'b1; exp_ir[k] = '0;
            for (int i = 0; i < 4; i++) dat[k][i] = 16'h0;
        end
        model_reset();

        // Idle reset, then requests present while still in reset: in_ready must stay low.
        run_cycle();
        run_cycle();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nch[k]; i++) begin
                iv[k][i] = 1'b1; dat[k][i] = 16'h1000 * 16'(i + 1);
            end
        end
        run_cycle();
        rst = 1'b0;

        for (int c = 0; c < 800; c++) run_cycle();

        // Asynchronous reset while outputs are valid.
        rnd_en = 1'b0;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        run_cycle();
        run_cycle();
        run_cycle();
        @(negedge clk);
        #2;
        for (int k = 0; k < 3; k++) chk($sformatf("d%0d_valid_pre_rst", k), 32'(ov_a[k]), 32'd1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_async_valid", k), 32'(ov_a[k]), 32'd0);
            chk($sformatf("d%0d_async_ready", k), 32'(ir_a[k]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle();
        for (int k = 0; k < 3; k++) chk($sformatf("d%0d_first_after_rst", k), 32'(os_a[k]), 32'd0);
        for (int c = 0; c < 8; c++) run_cycle();

        rnd_en = 1'b1;
        for (int c = 0; c < 300; c++) run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised successor to the combinational datapath mux: an N-channel arbitrated multiplexer with a registered output stage and per-channel valid/ready handshakes.
- Used where several LC-3 sources contend for one sink, e.g. memory-request sources in front of MAR/MDR or a shared write-back path.
- Selects one requesting channel per accepted transfer, using fixed-priority or round-robin selection.
- Registers the selected data together with the winning channel index.

Parameters:
- NCH, 4, number of input channels (2..16).
- SELW, 2, width of channel index; must equal clog2(NCH).
- DATASIZE, 16, data width per channel.
- MODE, 0, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NCH*DATASIZE  packed channel data; channel i occupies bits [(i+1)*DATASIZE-1 : i*DATASIZE].
- in_valid  input  NCH  channel i is presenting data.
- in_ready  output  NCH  channel i's data is accepted this cycle.
- out_data  output  DATASIZE  registered selected data.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  out_data and out_sel are valid.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, while rst=1):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is forced to all zeros combinationally.
- Load enable: load = !out_valid | out_ready. This is a single-entry pipeline register.
- Winner selection is combinational from in_valid:
  - MODE 0: lowest index i with in_valid[i]=1.
  - MODE 1: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... NCH-1, 0, ... rr_ptr-1 (modulo NCH).
- in_ready[i] = load & any_valid & (i == winner). It is one-hot or zero.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must not depend on in_ready.
- On a rising clock edge with load=1:
  - If any_valid: out_data <= in_data[winner], out_sel <= winner, out_valid <= 1.
  - Otherwise: out_valid <= 0; out_data and out_sel hold their previous values.
- With load=0 (out_valid=1 and out_ready=0): all outputs hold, all in_ready=0, and rr_ptr holds.
- Latency:
  - A transfer accepted in cycle n appears on the outputs in cycle n+1.
  - Full throughput: one transfer per cycle while out_ready=1.
- rr_ptr update (MODE 1 only), on an accepted transfer: rr_ptr <= (winner == NCH-1) ? 0 : winner+1. This wrap-around is explicit and does not rely on power-of-two NCH.
  - In MODE 0, rr_ptr stays 0 and is unused.
- Sources must hold in_data and in_valid until they see in_ready. The block never drops an asserted request.
- Simultaneous events:
  - The sink consumes (out_ready=1) and a new winner loads in the same edge: the new data replaces the old, with no bubble.
  - No valid inputs while out_ready=1: out_valid falls to 0 on the next edge.
- Reset mid-operation: a pending out_valid is discarded, and the arbiter restarts with channel 0 highest priority.
- NCH not a power of two: winner indices >= NCH never occur, and the search loops run only over 0..NCH-1.

Decomposition:
- Shared package `lc3_arb_pkg`:
  - Constants ARB_MODE_FIXED=0 and ARB_MODE_RR=1.
  - A clog2 function for SELW checks.
- One sub-module, `arb_picker`:
  - Parameters NCH, SELW, MODE.
  - Inputs req[NCH] and ptr[SELW]; outputs any and idx[SELW].
  - Purely combinational rotating priority search.
- The top level holds the output register, rr_ptr, and the handshake logic.
- Elaboration-time check: SELW == clog2(NCH), and MODE is in {0,1}.

Test Plan:
1. Reset release, idle: rst=1 for 3 cycles then 0, with in_valid=0000 and out_ready=1 → out_valid=0, out_sel=0, out_data=0000, in_ready=0000 throughout.
2. Fixed-priority contention: MODE=0, in_valid=1010, in_data ch1=0x1111, ch3=0x3333, out_ready=1 → in_ready=0010.
   - Next cycle: out_data=0x1111, out_sel=1, out_valid=1.
   - Ch3 is starved while ch1 stays valid.
3. Round-robin fairness: MODE=1, all four channels valid continuously with data 0xA000+i, out_ready=1 → grants in order 0,1,2,3,0,1.
   - out_sel sequence is 0,1,2,3,0 on consecutive cycles.
4. Backpressure hold: an output is valid with 0x2222, sel=2; out_ready=0 for 4 cycles while ch0/ch3 are valid → outputs hold at 0x2222/2, in_ready=0000, rr_ptr unchanged.
   - When out_ready=1, the next grant goes to ch3 under MODE=1 (ptr=3).
5. Drain and wrap: MODE=1, NCH=3 build, grant ch2 → rr_ptr=0.
   - Then in_valid=000 with out_ready=1 → out_valid drops to 0 next cycle; out_data holds.
6. Reset mid-transfer: assert rst asynchronously between edges while out_valid=1 → out_valid=0 immediately without a clock edge, and in_ready=0.
   - After release, with all channels valid and MODE=1, the first grant goes to ch0.
